dsp_mac_seq: RTL and testbench

DSP_MAC_SEQ -- requirements
Module: dsp_mac_seq

---
 rtl/dsp_mac_seq.sv | 176 +++++++++++++++++
 tb/tb_dsp_mac_seq.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_mac_seq.sv
// Sequences a job of signed 18x18 beats into an external DSP slice and returns the accumulated P.
// Optional build macro DSP_MAC_SEQ_SAT_EN clamps the captured result to the signed 36-bit range.
module dsp_mac_seq #(
  parameter int unsigned LEN_W     = 8,
  parameter int unsigned LATENCY   = 3,
  parameter int unsigned OPM_DLY   = 1,
  parameter logic [7:0]  OPM_FIRST = 8'h01,
  parameter logic [7:0]  OPM_ACC   = 8'h09,
  parameter logic [7:0]  OPM_HOLD  = 8'h08
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [17:0]      s_a,
  input  logic [17:0]      s_b,
  output logic [17:0]      dsp_A,
  output logic [17:0]      dsp_B,
  output logic [7:0]       dsp_opmode,
  output logic             dsp_ce,
  input  logic [47:0]      dsp_P,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [47:0]      res_data
);

  localparam int unsigned DrainW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned DrainLast = (LATENCY > 0) ? LATENCY - 1 : 0;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [DrainW-1:0] drain_q, drain_d;
  logic [17:0]       a_q, a_d;
  logic [17:0]       b_q, b_d;
  logic [7:0]        opm_q, opm_d;  // issue opmode, aligned with dsp_A/dsp_B
  logic              res_valid_q, res_valid_d;
  logic [47:0]       res_q, res_d;
  logic              beat, last_beat, drain_end;
  logic [47:0]       p_capt;

`ifdef DSP_MAC_SEQ_SAT_EN
  localparam logic [47:0] SatMax = {13'h0000, {35{1'b1}}};
  localparam logic [47:0] SatMin = {{13{1'b1}}, 35'h0};

  // In range iff the top 13 bits all match the 36-bit sign bit.
  always_comb begin
    if (dsp_P[47:35] == 13'h0000 || dsp_P[47:35] == 13'h1fff) begin
      p_capt = dsp_P;
    end else if (dsp_P[47]) begin
      p_capt = SatMin;
    end else begin
      p_capt = SatMax;
    end
  end
`else
  assign p_capt = dsp_P;
`endif

  always_comb begin
    beat      = (state_q == StRun) && s_valid;
    last_beat = beat && (cnt_q == len_q - LEN_W'(1));
    drain_end = (state_q == StDrain) && (drain_q == DrainW'(DrainLast));
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    drain_d     = drain_q;
    a_d         = '0;
    b_d         = '0;
    opm_d       = OPM_HOLD;
    res_valid_d = res_valid_q;
    res_d       = res_q;

    unique case (state_q)
      StIdle: begin
        if (start && (len != '0)) begin
          len_d   = len;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (beat) begin
          a_d   = s_a;
          b_d   = s_b;
          opm_d = (cnt_q == '0) ? OPM_FIRST : OPM_ACC;
          cnt_d = cnt_q + LEN_W'(1);
          if (last_beat) begin
            drain_d = '0;
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        drain_d = drain_q + DrainW'(1);
        if (drain_end) begin
          res_d       = p_capt;
          res_valid_d = 1'b1;
          state_d     = StDone;
        end
      end
      StDone: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StIdle;
      len_q       <= '0;
      cnt_q       <= '0;
      drain_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      opm_q       <= OPM_HOLD;
      res_valid_q <= 1'b0;
      res_q       <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      drain_q     <= drain_d;
      a_q         <= a_d;
      b_q         <= b_d;
      opm_q       <= opm_d;
      res_valid_q <= res_valid_d;
      res_q       <= res_d;
    end
  end

  // Opmode trails the operands so it meets the product inside the slice pipeline.
  generate
    if (OPM_DLY == 0) begin : g_no_dly
      assign dsp_opmode = opm_q;
    end else begin : g_dly
      logic [7:0] line_q [OPM_DLY];

      always_ff @(posedge CLK) begin
        if (RST) begin
          for (int i = 0; i < OPM_DLY; i++) begin
            line_q[i] <= OPM_HOLD;
          end
        end else begin
          line_q[0] <= opm_q;
          for (int i = 1; i < OPM_DLY; i++) begin
            line_q[i] <= line_q[i-1];
          end
        end
      end

      assign dsp_opmode = line_q[OPM_DLY-1];
    end
  endgenerate

  assign busy      = (state_q != StIdle);
  assign s_ready   = (state_q == StRun);
  assign dsp_ce    = busy;
  assign dsp_A     = a_q;
  assign dsp_B     = b_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_q;

endmodule

// File: tb/tb_dsp_mac_seq.sv
// Directed bench for dsp_mac_seq with a behavioural DSP slice (M and P registers) and a result
// scoreboard; follows DSP_MAC_SEQ_SAT_EN for the expected capture value.
module tb_dsp_mac_seq;

  localparam int unsigned LEN_W     = 8;
  localparam int unsigned LATENCY   = 3;
  localparam int unsigned OPM_DLY   = 1;
  localparam logic [7:0]  OPM_FIRST = 8'h01;
  localparam logic [7:0]  OPM_ACC   = 8'h09;
  localparam logic [7:0]  OPM_HOLD  = 8'h08;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             busy;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [17:0]      s_a = '0;
  logic [17:0]      s_b = '0;
  logic [17:0]      dsp_A;
  logic [17:0]      dsp_B;
  logic [7:0]       dsp_opmode;
  logic             dsp_ce;
  logic [47:0]      dsp_P;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [47:0]      res_data;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int acc_cyc = 0;

  logic signed [47:0] sb [$];
  int                 qa [$];
  int                 qb [$];
  logic [7:0]         opm_trace [$];

  logic signed [35:0] m_q = '0;
  logic signed [47:0] p_q = '0;

  dsp_mac_seq #(
    .LEN_W    (LEN_W),
    .LATENCY  (LATENCY),
    .OPM_DLY  (OPM_DLY),
    .OPM_FIRST(OPM_FIRST),
    .OPM_ACC  (OPM_ACC),
    .OPM_HOLD (OPM_HOLD)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .start     (start),
    .len       (len),
    .busy      (busy),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_a       (s_a),
    .s_b       (s_b),
    .dsp_A     (dsp_A),
    .dsp_B     (dsp_B),
    .dsp_opmode(dsp_opmode),
    .dsp_ce    (dsp_ce),
    .dsp_P     (dsp_P),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Slice model: operands reach M one cycle after issue, P one cycle later under the opmode.
  always @(posedge CLK) begin
    if (dsp_ce) begin
      m_q <= $signed(dsp_A) * $signed(dsp_B);
      if (dsp_opmode == OPM_FIRST) p_q <= {{12{m_q[35]}}, m_q};
      else if (dsp_opmode == OPM_ACC) p_q <= p_q + {{12{m_q[35]}}, m_q};
    end
  end
  assign dsp_P = p_q;

  always @(negedge CLK) if (busy) opm_trace.push_back(dsp_opmode);

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [47:0] model_sum();
    logic signed [47:0] acc;
    longint             prod;
    acc = '0;
    foreach (qa[i]) begin
      prod = longint'(qa[i]) * longint'(qb[i]);
      acc  = acc + 48'(prod);
    end
`ifdef DSP_MAC_SEQ_SAT_EN
    if (longint'(acc) > 64'sd34359738367) acc = 48'sd34359738367;
    else if (longint'(acc) < -64'sd34359738368) acc = -48'sd34359738368;
`endif
    return acc;
  endfunction

  task automatic run_job(input int gap);
    int n;
    n = qa.size();
    opm_trace.delete();
    sb.push_back(model_sum());
    start = 1'b1;
    len   = LEN_W'(n);
    step();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) step();
      end
      s_valid = 1'b1;
      s_a     = 18'(qa[i]);
      s_b     = 18'(qb[i]);
      acc_cyc = cyc;
      step();
      s_valid = 1'b0;
    end
  endtask

  task automatic wait_result(input string tag);
    int                 waited;
    logic signed [47:0] exp;
    waited = 0;
    while (res_valid !== 1'b1 && waited < 40) begin
      step();
      waited++;
    end
    check({tag, "_valid"}, {63'd0, res_valid}, 64'sd1);
    check({tag, "_lat"}, cyc - acc_cyc, LATENCY + 1);
    exp = (sb.size() > 0) ? sb.pop_front() : 48'sd0;
    check({tag, "_data"}, $signed(res_data), exp);
  endtask

  task automatic release_result(input string tag);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check({tag, "_rv_clr"}, {63'd0, res_valid}, 64'sd0);
    check({tag, "_idle"}, {63'd0, busy}, 64'sd0);
  endtask

  task automatic check_opm(input string tag, input int n, input int gap);
    int k;
    int holds;
    k     = 0;
    holds = 0;
    foreach (opm_trace[i]) begin
      if (opm_trace[i] != OPM_HOLD) begin
        check($sformatf("%s_opm%0d", tag, k), opm_trace[i], (k == 0) ? OPM_FIRST : OPM_ACC);
        if (k > 0) check($sformatf("%s_gap%0d", tag, k), holds, gap);
        k++;
        holds = 0;
      end else begin
        holds++;
      end
    end
    check({tag, "_nissue"}, k, n);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, {63'd0, busy}, 64'sd0);
    check({tag, "_srdy"}, {63'd0, s_ready}, 64'sd0);
    check({tag, "_rv"}, {63'd0, res_valid}, 64'sd0);
    check({tag, "_rd"}, $signed(res_data), 64'sd0);
    check({tag, "_A"}, dsp_A, 64'sd0);
    check({tag, "_B"}, dsp_B, 64'sd0);
    check({tag, "_ce"}, {63'd0, dsp_ce}, 64'sd0);
    check({tag, "_opm"}, dsp_opmode, OPM_HOLD);
  endtask

  initial begin
    step();
    step();
    RST = 1'b0;
    check_zero("reset");

    // len=0 start is ignored
    start = 1'b1;
    len   = '0;
    step();
    start = 1'b0;
    check("len0_busy", {63'd0, busy}, 64'sd0);

    // single beat
    qa = '{3};
    qb = '{4};
    run_job(0);
    check("single_srdy_drop", {63'd0, s_ready}, 64'sd0);
    wait_result("single");
    check("single_lit", $signed(res_data), 64'sd12);
    release_result("single");

    // back-to-back four beats with mixed signs
    qa = '{1, 3, -5, 7};
    qb = '{2, 4, 6, -8};
    run_job(0);
    wait_result("b2b");
    check("b2b_lit", $signed(res_data), -64'sd72);
    release_result("b2b");
    check_opm("b2b", 4, 0);

    // gaps between beats
    qa = '{2, 2, 2};
    qb = '{2, 2, 2};
    run_job(2);
    wait_result("gap");
    release_result("gap");
    check_opm("gap", 3, 2);

    // result backpressure with start held high
    qa = '{3};
    qb = '{4};
    run_job(0);
    wait_result("hold");
    start = 1'b1;
    len   = LEN_W'(1);
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("hold_rv%0d", i), {63'd0, res_valid}, 64'sd1);
      check($sformatf("hold_rd%0d", i), $signed(res_data), 64'sd12);
      check($sformatf("hold_srdy%0d", i), {63'd0, s_ready}, 64'sd0);
      check($sformatf("hold_ce%0d", i), {63'd0, dsp_ce}, 64'sd1);
    end
    start = 1'b0;
    release_result("hold");

    // reset in the middle of a job
    start = 1'b1;
    len   = LEN_W'(4);
    step();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1;
      s_a     = 18'(i + 1);
      s_b     = 18'(i + 2);
      step();
    end
    s_valid = 1'b0;
    RST = 1'b1;
    step();
    RST = 1'b0;
    check_zero("midrst");
    qa = '{5};
    qb = '{5};
    run_job(0);
    wait_result("postrst");
    check("postrst_lit", $signed(res_data), 64'sd25);
    release_result("postrst");

    // large products: wrap or saturate
    qa = '{131071, 131071, 131071};
    qb = '{131071, 131071, 131071};
    run_job(0);
    wait_result("big");
`ifdef DSP_MAC_SEQ_SAT_EN
    check("big_lit", $signed(res_data), 64'sd34359738367);
`else
    check("big_lit", $signed(res_data), 64'sd51538821123);
`endif
    release_result("big");

    check("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
